// File: rtl/trx_pwr_seq_pkg.sv
// trx_pwr_seq_pkg: shared types and default timing for the RF
// front-end power-up sequencer.
package trx_pwr_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIAS = 3'd1,
    ST_LOCK = 3'd2,
    ST_RUN  = 3'd3,
    ST_DOWN = 3'd4,
    ST_FAIL = 3'd5
  } state_e;

  typedef enum logic {
    OWN_RX = 1'b0,
    OWN_TX = 1'b1
  } owner_e;

  localparam int BIAS_CYC_DEF    = 50;
  localparam int LOCK_TO_CYC_DEF = 100;
  localparam int CNT_W_DEF       = 8;

endpackage

// File: rtl/trx_pwr_seq_timer.sv
// seq_timer: loadable down-counter that saturates at zero,
// shared by the bias-settle and lock-timeout phases.
module seq_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // load wins over decrement; hold at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = value;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/trx_pwr_seq.sv
// trx_pwr_seq: RX/TX power-up arbiter and bias/PLL sequencer.
// Define TRX_PWR_SEQ_LOCK_TIMEOUT_EN to enable lock timeout / FAIL.
module trx_pwr_seq
  import trx_pwr_seq_pkg::*;
#(
  parameter int BIAS_CYC    = BIAS_CYC_DEF,
  parameter int LOCK_TO_CYC = LOCK_TO_CYC_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic PU_RX,
  input  logic PU_TX,
  input  logic PLL_LOCK,
  output logic EN_BIAS,
  output logic EN_PLL,
  output logic EN_LNA,
  output logic EN_PA,
  output logic RDY_RX,
  output logic RDY_TX,
  output logic ERR
);

  localparam logic [CNT_W-1:0] BIAS_LD = CNT_W'(BIAS_CYC - 1);
  localparam logic [CNT_W-1:0] LOCK_LD = CNT_W'(LOCK_TO_CYC - 1);

  state_e state_q, state_d;
  owner_e owner_q, owner_d;
  owner_e last_q, last_d;

  logic en_bias_q, en_bias_d;
  logic en_pll_q, en_pll_d;
  logic en_lna_q, en_lna_d;
  logic en_pa_q, en_pa_d;
  logic rdy_rx_q, rdy_rx_d;
  logic rdy_tx_q, rdy_tx_d;
  logic err_q, err_d;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_value;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             own_req;

  seq_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (CLK),
    .rst   (RST),
    .load  (tmr_load),
    .value (tmr_value),
    .dec   (tmr_dec),
    .zero  (tmr_zero)
  );

  assign own_req = (owner_q == OWN_RX) ? PU_RX : PU_TX;

  // next-state, next-output and timer control
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    en_bias_d = en_bias_q;
    en_pll_d  = en_pll_q;
    en_lna_d  = en_lna_q;
    en_pa_d   = en_pa_q;
    rdy_rx_d  = rdy_rx_q;
    rdy_tx_d  = rdy_tx_q;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    tmr_dec   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (PU_RX || PU_TX) begin
          if (PU_RX && PU_TX) begin
            owner_d = (last_q == OWN_RX) ? OWN_TX : OWN_RX;
          end else begin
            owner_d = PU_RX ? OWN_RX : OWN_TX;
          end
          state_d   = ST_BIAS;
          en_bias_d = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = BIAS_LD;
        end
      end

      ST_BIAS, ST_LOCK, ST_RUN: begin
        if (!own_req) begin
          state_d  = ST_DOWN;
          en_pll_d = 1'b0;
          en_lna_d = 1'b0;
          en_pa_d  = 1'b0;
          rdy_rx_d = 1'b0;
          rdy_tx_d = 1'b0;
        end else if (state_q == ST_BIAS) begin
          if (tmr_zero) begin
            state_d   = ST_LOCK;
            en_pll_d  = 1'b1;
            tmr_load  = 1'b1;
            tmr_value = LOCK_LD;
          end else begin
            tmr_dec = 1'b1;
          end
        end else if (state_q == ST_LOCK) begin
          if (PLL_LOCK) begin
            state_d = ST_RUN;
            if (owner_q == OWN_RX) begin
              en_lna_d = 1'b1;
              rdy_rx_d = 1'b1;
            end else begin
              en_pa_d  = 1'b1;
              rdy_tx_d = 1'b1;
            end
          end else begin
`ifdef TRX_PWR_SEQ_LOCK_TIMEOUT_EN
            if (tmr_zero) begin
              state_d = ST_FAIL;
              last_d  = owner_q;
            end else begin
              tmr_dec = 1'b1;
            end
`else
            tmr_dec = 1'b1;
`endif
          end
        end else if (!PLL_LOCK) begin
          state_d   = ST_LOCK;
          en_lna_d  = 1'b0;
          en_pa_d   = 1'b0;
          rdy_rx_d  = 1'b0;
          rdy_tx_d  = 1'b0;
          tmr_load  = 1'b1;
          tmr_value = LOCK_LD;
        end
      end

      ST_DOWN: begin
        state_d   = ST_IDLE;
        en_bias_d = 1'b0;
        last_d    = owner_q;
      end

      ST_FAIL: begin
`ifdef TRX_PWR_SEQ_LOCK_TIMEOUT_EN
        // first FAIL cycle shuts everything down and flags
        if (!err_q) begin
          err_d     = 1'b1;
          en_bias_d = 1'b0;
          en_pll_d  = 1'b0;
          en_lna_d  = 1'b0;
          en_pa_d   = 1'b0;
          rdy_rx_d  = 1'b0;
          rdy_tx_d  = 1'b0;
        end else if (!PU_RX && !PU_TX) begin
          state_d = ST_IDLE;
          err_d   = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // sequencer state and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      owner_q   <= OWN_TX;
      last_q    <= OWN_TX;
      en_bias_q <= 1'b0;
      en_pll_q  <= 1'b0;
      en_lna_q  <= 1'b0;
      en_pa_q   <= 1'b0;
      rdy_rx_q  <= 1'b0;
      rdy_tx_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      en_bias_q <= en_bias_d;
      en_pll_q  <= en_pll_d;
      en_lna_q  <= en_lna_d;
      en_pa_q   <= en_pa_d;
      rdy_rx_q  <= rdy_rx_d;
      rdy_tx_q  <= rdy_tx_d;
      err_q     <= err_d;
    end
  end

  assign EN_BIAS = en_bias_q;
  assign EN_PLL  = en_pll_q;
  assign EN_LNA  = en_lna_q;
  assign EN_PA   = en_pa_q;
  assign RDY_RX  = rdy_rx_q;
  assign RDY_TX  = rdy_tx_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_trx_pwr_seq.sv
// tb_trx_pwr_seq: directed vector bench for trx_pwr_seq.
// Output vector order: {ERR,RDY_TX,RDY_RX,EN_PA,EN_LNA,EN_PLL,EN_BIAS}.
module tb_trx_pwr_seq;

  logic CLK;
  logic RST;
  logic PU_RX;
  logic PU_TX;
  logic PLL_LOCK;
  logic EN_BIAS;
  logic EN_PLL;
  logic EN_LNA;
  logic EN_PA;
  logic RDY_RX;
  logic RDY_TX;
  logic ERR;

  logic [6:0] outs;

  int nvec;
  int nerr;

  typedef struct {
    logic       rst;
    logic       rx;
    logic       tx;
    logic       lk;
    int         cyc;
    logic [6:0] exp;
    string      name;
  } vec_t;

  vec_t tbl[$];

`ifdef TRX_PWR_SEQ_LOCK_TIMEOUT_EN
  localparam logic [6:0] EXP_TO   = 7'b1000000;
  localparam logic [6:0] EXP_EXIT = 7'b0000000;
`else
  localparam logic [6:0] EXP_TO   = 7'b0000011;
  localparam logic [6:0] EXP_EXIT = 7'b0000001;
`endif

  trx_pwr_seq dut (
    .CLK      (CLK),
    .RST      (RST),
    .PU_RX    (PU_RX),
    .PU_TX    (PU_TX),
    .PLL_LOCK (PLL_LOCK),
    .EN_BIAS  (EN_BIAS),
    .EN_PLL   (EN_PLL),
    .EN_LNA   (EN_LNA),
    .EN_PA    (EN_PA),
    .RDY_RX   (RDY_RX),
    .RDY_TX   (RDY_TX),
    .ERR      (ERR)
  );

  assign outs = {ERR, RDY_TX, RDY_RX, EN_PA,
                 EN_LNA, EN_PLL, EN_BIAS};

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string nm,
                     input logic [6:0] want);
    nvec++;
    if (outs !== want) begin
      nerr++;
      $display("FAIL %s: got %b want %b at %0t",
               nm, outs, want, $time);
    end
  endtask

  task automatic add(input logic r, input logic rx,
                     input logic tx, input logic lk,
                     input int c, input logic [6:0] e,
                     input string nm);
    vec_t v;
    v.rst = r; v.rx = rx; v.tx = tx; v.lk = lk;
    v.cyc = c; v.exp = e; v.name = nm;
    tbl.push_back(v);
  endtask

  always @(negedge CLK) begin
    nvec++;
    if ((EN_LNA && EN_PA) || (RDY_RX && RDY_TX)) begin
      nerr++;
      $display("FAIL mutex: got %b want one-hot paths",
               outs);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] e;
    nvec = 0;
    nerr = 0;

    // rst rx tx lk cyc exp name
    add(1, 1, 0, 1, 0,  7'b0000000, "async_rst");
    add(1, 0, 1, 1, 2,  7'b0000000, "rst_hold");
    add(0, 0, 1, 1, 1,  7'b0000001, "tx_only_grant");
    add(0, 0, 1, 1, 50, 7'b0000011, "tx_pll");
    add(0, 0, 1, 1, 1,  7'b0101011, "tx_rdy");
    add(0, 0, 0, 1, 1,  7'b0000001, "tx_down");
    add(0, 0, 0, 1, 1,  7'b0000000, "tx_idle");
    add(1, 0, 0, 1, 1,  7'b0000000, "rst2");
    add(0, 1, 1, 1, 1,  7'b0000001, "both_grant");
    add(0, 1, 1, 1, 50, 7'b0000011, "both_pll");
    add(0, 1, 1, 1, 1,  7'b0010111, "rx_wins");
    add(0, 1, 1, 0, 1,  7'b0000011, "lock_drop");
    add(0, 1, 1, 0, 2,  7'b0000011, "lock_low");
    add(0, 1, 1, 1, 1,  7'b0010111, "lock_back");
    add(0, 0, 1, 1, 1,  7'b0000001, "rx_down");
    add(0, 0, 1, 1, 1,  7'b0000000, "rx_idle");
    add(0, 0, 1, 1, 1,  7'b0000001, "tx_grant");
    add(0, 0, 1, 1, 50, 7'b0000011, "tx_pll2");
    add(0, 0, 1, 1, 1,  7'b0101011, "tx_rdy2");
    add(0, 0, 0, 1, 1,  7'b0000001, "tx_down2");
    add(0, 0, 0, 1, 1,  7'b0000000, "tx_idle2");
    add(0, 0, 1, 1, 1,  7'b0000001, "bias_grant");
    add(0, 0, 1, 1, 19, 7'b0000001, "bias_e20");
    add(0, 0, 0, 1, 1,  7'b0000001, "bias_rel_down");
    add(0, 0, 0, 1, 1,  7'b0000000, "bias_rel_idle");
    add(0, 0, 0, 1, 40, 7'b0000000, "stay_idle");
    add(0, 1, 1, 1, 1,  7'b0000001, "rr_grant_rx");
    add(0, 1, 1, 1, 51, 7'b0010111, "rr_rx");
    add(0, 0, 1, 1, 1,  7'b0000001, "rr_down");
    add(0, 1, 1, 1, 1,  7'b0000000, "rr_idle");
    add(0, 1, 1, 1, 1,  7'b0000001, "rr_grant_tx");
    add(0, 1, 1, 1, 51, 7'b0101011, "rr_tx");
    add(1, 0, 0, 0, 1,  7'b0000000, "rst3");
    add(0, 1, 0, 0, 1,  7'b0000001, "to_grant");
    add(0, 1, 0, 0, 150, 7'b0000011, "pre_timeout");
    add(0, 1, 0, 0, 1,  EXP_TO,     "timeout");
    add(0, 1, 0, 0, 5,  EXP_TO,     "fail_hold");
    add(0, 0, 0, 0, 1,  EXP_EXIT,   "fail_exit");
    add(0, 0, 0, 0, 1,  7'b0000000, "idle_after");
    add(0, 1, 1, 1, 1,  7'b0000001, "post_grant");
    add(0, 1, 1, 1, 51, 7'b0101011, "post_tx");

    RST = 1'b1;
    PU_RX = 1'b0;
    PU_TX = 1'b0;
    PLL_LOCK = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset", 7'b0000000);
    RST = 1'b0;
    @(posedge CLK);
    #1;

    // RX power-up with lock tied high, edge-by-edge
    PU_RX = 1'b1;
    PLL_LOCK = 1'b1;
    for (int k = 1; k <= 55; k++) begin
      @(posedge CLK);
      #1;
      e = 7'b0000000;
      e[0] = 1'b1;
      e[1] = (k >= 51);
      e[2] = (k >= 52);
      e[4] = (k >= 52);
      chk($sformatf("rx_seq_e%0d", k), e);
    end

    foreach (tbl[i]) begin
      RST = tbl[i].rst;
      PU_RX = tbl[i].rx;
      PU_TX = tbl[i].tx;
      PLL_LOCK = tbl[i].lk;
      if (tbl[i].cyc == 0) begin
        #1;
      end else begin
        repeat (tbl[i].cyc) @(posedge CLK);
        #1;
      end
      chk(tbl[i].name, tbl[i].exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
